// File: rtl/fft_pkg.sv
// Shared FFT constants, read-FSM state type and the bit-reversal helper used
// to place bit-reversed-order samples into natural-order storage.
package fft_pkg;

  localparam int FFT_N         = 32;
  localparam int FFT_LOG2N     = 5;
  localparam int FFT_NBITS_OUT = 15;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  // Reverse the low nbits of k; bits above nbits come back as zero.
  function automatic int bitrev(input int k, input int nbits);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) r[nbits-1-i] = k[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One N-word sample bank: four scattered write ports sharing one enable and
// four read ports covering the aligned quad at row i_rrow.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = FFT_NBITS_OUT
) (
  input  logic                           i_clk,
  input  logic                           i_we,
  input  logic [3:0][$clog2(N)-1:0]      i_waddr,
  input  logic [3:0][W-1:0]              i_wdata,
  input  logic [$clog2(N)-3:0]           i_rrow,
  output logic [3:0][W-1:0]              o_rdata
);

  logic [W-1:0] r_mem [N];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int l = 0; l < 4; l++) r_mem[i_waddr[l]] <= i_wdata[l];
    end
  end

  always_comb begin
    for (int l = 0; l < 4; l++) o_rdata[l] = r_mem[{i_rrow, 2'(l)}];
  end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer turning 4-lane bit-reversed FFT output into
// natural frequency order, with frame markers and partial-frame drop detection.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int NBITS_OUT = FFT_NBITS_OUT,
  parameter int N         = FFT_N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NBITS_OUT-1:0] in0_up,
  input  logic [NBITS_OUT-1:0] in0_down,
  input  logic [NBITS_OUT-1:0] in1_up,
  input  logic [NBITS_OUT-1:0] in1_down,
  input  logic                 in_valid,
  input  logic                 in_sof,
  output logic [NBITS_OUT-1:0] out0_up,
  output logic [NBITS_OUT-1:0] out0_down,
  output logic [NBITS_OUT-1:0] out1_up,
  output logic [NBITS_OUT-1:0] out1_down,
  output logic                 out_valid,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 err_drop
);

  localparam int AW = $clog2(N);
  localparam int CW = AW - 2;
  localparam logic [CW-1:0] LAST_ROW = CW'(N/4 - 1);

  logic [CW-1:0]                r_wrCnt;
  logic                         r_wrBank;
  logic                         r_frameOpen;
  logic                         r_errDrop;
  logic [1:0]                   r_full;
  rd_state_t                    r_state;
  logic [CW-1:0]                r_rdCnt;
  logic                         r_rdBank;
  logic [3:0][NBITS_OUT-1:0]    r_outData;
  logic                         r_outValid;
  logic                         r_outSof;
  logic                         r_outEof;

  logic                         w_wrEn;
  logic                         w_wrLast;
  logic                         w_drop;
  logic [CW-1:0]                w_wrRow;
  logic [3:0][AW-1:0]           w_wrAddr;
  logic [3:0][NBITS_OUT-1:0]    w_wrData;
  logic                         w_rdSel;
  logic                         w_rdEn;
  logic                         w_rdLast;
  rd_state_t                    w_stateNext;
  logic [CW-1:0]                w_rdCntNext;
  logic                         w_rdBankNext;
  logic [1:0]                   w_fullNext;
  logic [3:0][NBITS_OUT-1:0]    w_bank0Data;
  logic [3:0][NBITS_OUT-1:0]    w_bank1Data;
  logic [3:0][NBITS_OUT-1:0]    w_rdData;

  // A start-of-frame always restarts at row 0, discarding any open frame.
  always_comb begin
    w_wrEn   = in_valid && (in_sof || r_frameOpen);
    w_wrRow  = in_sof ? '0 : r_wrCnt;
    w_wrLast = w_wrEn && (w_wrRow == LAST_ROW);
    w_drop   = in_valid && in_sof && r_frameOpen;
    w_wrData = {in1_down, in1_up, in0_down, in0_up};
    for (int l = 0; l < 4; l++) begin
      w_wrAddr[l] = AW'(bitrev(int'({w_wrRow, 2'(l)}), AW));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrCnt     <= '0;
      r_wrBank    <= 1'b0;
      r_frameOpen <= 1'b0;
      r_errDrop   <= 1'b0;
    end else begin
      r_errDrop <= w_drop;
      if (w_wrEn) begin
        if (w_wrLast) begin
          r_wrCnt     <= '0;
          r_frameOpen <= 1'b0;
          r_wrBank    <= ~r_wrBank;
        end else begin
          r_wrCnt     <= w_wrRow + 1'b1;
          r_frameOpen <= 1'b1;
        end
      end
    end
  end

  fft_reorder_bank #(.N(N), .W(NBITS_OUT)) u_bank0 (
    .i_clk   (clk),
    .i_we    (w_wrEn && !r_wrBank),
    .i_waddr (w_wrAddr),
    .i_wdata (w_wrData),
    .i_rrow  (r_rdCnt),
    .o_rdata (w_bank0Data)
  );

  fft_reorder_bank #(.N(N), .W(NBITS_OUT)) u_bank1 (
    .i_clk   (clk),
    .i_we    (w_wrEn && r_wrBank),
    .i_waddr (w_wrAddr),
    .i_wdata (w_wrData),
    .i_rrow  (r_rdCnt),
    .o_rdata (w_bank1Data)
  );

  // Reads are issued in the same cycle IDLE sees a full bank, so the
  // registered output appears one cycle after the completing write edge.
  always_comb begin
    w_rdSel = r_rdBank;
    if (r_state == RD_IDLE && !r_full[r_rdBank]) w_rdSel = ~r_rdBank;
    w_rdEn       = r_full[w_rdSel];
    w_rdLast     = w_rdEn && (r_rdCnt == LAST_ROW);
    w_stateNext  = r_state;
    w_rdCntNext  = r_rdCnt;
    w_rdBankNext = r_rdBank;
    if (w_rdEn) begin
      if (w_rdLast) begin
        w_rdCntNext  = '0;
        w_rdBankNext = ~w_rdSel;
        w_stateNext  = r_full[~w_rdSel] ? RD_READ : RD_IDLE;
      end else begin
        w_rdCntNext  = r_rdCnt + 1'b1;
        w_rdBankNext = w_rdSel;
        w_stateNext  = RD_READ;
      end
    end
    w_fullNext = r_full;
    if (w_rdLast) w_fullNext[w_rdSel]  = 1'b0;
    if (w_wrLast) w_fullNext[r_wrBank] = 1'b1;
    w_rdData = w_rdSel ? w_bank1Data : w_bank0Data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= RD_IDLE;
      r_rdCnt    <= '0;
      r_rdBank   <= 1'b0;
      r_full     <= 2'b00;
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_outSof   <= 1'b0;
      r_outEof   <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_rdCnt    <= w_rdCntNext;
      r_rdBank   <= w_rdBankNext;
      r_full     <= w_fullNext;
      r_outData  <= w_rdEn ? w_rdData : '0;
      r_outValid <= w_rdEn;
      r_outSof   <= w_rdEn && (r_rdCnt == '0);
      r_outEof   <= w_rdLast;
    end
  end

  assign out0_up   = r_outData[0];
  assign out0_down = r_outData[1];
  assign out1_up   = r_outData[2];
  assign out1_down = r_outData[3];
  assign out_valid = r_outValid;
  assign out_sof   = r_outSof;
  assign out_eof   = r_outEof;
  assign err_drop  = r_errDrop;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder (N=32): frames are pushed as expected
// natural-order rows when sent; a negedge monitor pops and compares.
module tb_fft_out_reorder;

  logic        clk;
  logic        rst;
  logic [14:0] in0_up, in0_down, in1_up, in1_down;
  logic        in_valid, in_sof;
  logic [14:0] out0_up, out0_down, out1_up, out1_down;
  logic        out_valid, out_sof, out_eof, err_drop;

  typedef struct {
    int l0; int l1; int l2; int l3;
    bit sof; bit eof;
  } row_t;

  row_t sb[$];
  int   totalChecks = 0;
  int   badChecks = 0;
  int   cyc = 0;
  int   frameStartCyc = 0;
  int   validCount = 0;
  int   runLen = 0;
  int   maxRun = 0;
  int   errDropCount = 0;
  bit   monEnable = 0;
  bit   captEnable = 0;
  int   captIdx = 0;
  int   capt[8][4];
  int   captSof[8];
  int   captEof[8];

  fft_out_reorder #(.NBITS_OUT(15), .N(32)) dut (
    .clk(clk), .rst(rst),
    .in0_up(in0_up), .in0_down(in0_down), .in1_up(in1_up), .in1_down(in1_down),
    .in_valid(in_valid), .in_sof(in_sof),
    .out0_up(out0_up), .out0_down(out0_down), .out1_up(out1_up), .out1_down(out1_down),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .err_drop(err_drop)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int tbBitrev5(int k);
    int r = 0;
    for (int i = 0; i < 5; i++) r |= ((k >> i) & 1) << (4 - i);
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s actual=%0d required=%0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExpected(input int base);
    row_t row;
    for (int r = 0; r < 8; r++) begin
      row.l0  = base + tbBitrev5(4*r);
      row.l1  = base + tbBitrev5(4*r + 1);
      row.l2  = base + tbBitrev5(4*r + 2);
      row.l3  = base + tbBitrev5(4*r + 3);
      row.sof = (r == 0);
      row.eof = (r == 7);
      sb.push_back(row);
    end
  endtask

  // One input cycle: lanes carry base + 4c + l.
  task automatic applyStimulus(input bit v, input bit sof, input int base, input int c);
    in_valid = v;
    in_sof   = sof;
    in0_up   = 15'(base + 4*c);
    in0_down = 15'(base + 4*c + 1);
    in1_up   = 15'(base + 4*c + 2);
    in1_down = 15'(base + 4*c + 3);
    @(posedge clk); #1;
    in_valid = 0;
    in_sof   = 0;
  endtask

  task automatic sendFrame(input int base, input bit gaps);
    for (int c = 0; c < 8; c++) begin
      if (gaps) begin
        for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
          @(posedge clk); #1;
        end
      end
      if (c == 0) frameStartCyc = cyc;
      applyStimulus(1, c == 0, base, c);
    end
    pushExpected(base);
  endtask

  task automatic waitValid(output bit found);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = out_valid;
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("drain_queue", sb.size(), 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (err_drop) errDropCount++;
    if (monEnable) begin
      if (out_valid) begin
        row_t e;
        validCount++;
        runLen++;
        if (runLen > maxRun) maxRun = runLen;
        if (captEnable && captIdx < 8) begin
          capt[captIdx][0] = out0_up;  capt[captIdx][1] = out0_down;
          capt[captIdx][2] = out1_up;  capt[captIdx][3] = out1_down;
          captSof[captIdx] = out_sof;  captEof[captIdx] = out_eof;
          captIdx++;
        end
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", int'(out_valid), 0);
        end else begin
          e = sb.pop_front();
          checkOutput("lane0", int'(out0_up), e.l0);
          checkOutput("lane1", int'(out0_down), e.l1);
          checkOutput("lane2", int'(out1_up), e.l2);
          checkOutput("lane3", int'(out1_down), e.l3);
          checkOutput("sof", int'(out_sof), int'(e.sof));
          checkOutput("eof", int'(out_eof), int'(e.eof));
        end
      end else begin
        runLen = 0;
        checkOutput("idle_zero", int'(out0_up | out0_down | out1_up | out1_down) + int'(out_sof) + int'(out_eof), 0);
      end
    end
  end

  initial begin
    bit found;
    int snapValid;
    int snapDrop;

    rst = 0; in_valid = 0; in_sof = 0;
    in0_up = 0; in0_down = 0; in1_up = 0; in1_down = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_sof_eof", int'(out_sof) + int'(out_eof), 0);
    checkOutput("rst_err_drop", int'(err_drop), 0);
    checkOutput("rst_lanes", int'(out0_up | out0_down | out1_up | out1_down), 0);
    rst = 1;
    monEnable = 1;
    @(posedge clk); #1;

    $display("[TB] single frame, sample value k");
    captEnable = 1; captIdx = 0; validCount = 0;
    sendFrame(0, 0);
    waitValid(found);
    if (found) checkOutput("first_latency", cyc - frameStartCyc, 9);
    else checkOutput("first_valid", int'(out_valid), 1);
    waitDrain();
    captEnable = 0;
    checkOutput("single_valid_cycles", validCount, 8);
    checkOutput("r0_l0", capt[0][0], 0);
    checkOutput("r0_l1", capt[0][1], 16);
    checkOutput("r0_l2", capt[0][2], 8);
    checkOutput("r0_l3", capt[0][3], 24);
    checkOutput("r7_l0", capt[7][0], 7);
    checkOutput("r7_l1", capt[7][1], 23);
    checkOutput("r7_l2", capt[7][2], 15);
    checkOutput("r7_l3", capt[7][3], 31);
    checkOutput("r0_sof", captSof[0], 1);
    checkOutput("r7_eof", captEof[7], 1);

    $display("[TB] three back-to-back frames");
    maxRun = 0; validCount = 0;
    sendFrame(100, 0);
    sendFrame(200, 0);
    sendFrame(300, 0);
    waitDrain();
    checkOutput("b2b_contiguous", maxRun, 24);
    checkOutput("b2b_valid_cycles", validCount, 24);

    $display("[TB] in_valid without sof is ignored");
    snapValid = validCount; snapDrop = errDropCount;
    applyStimulus(1, 0, 900, 0);
    applyStimulus(1, 0, 900, 1);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("orphan_no_output", validCount - snapValid, 0);
    sendFrame(950, 0);
    waitDrain();
    checkOutput("orphan_no_drop", errDropCount - snapDrop, 0);

    $display("[TB] partial frame dropped by early sof");
    snapDrop = errDropCount; validCount = 0;
    for (int c = 0; c < 5; c++) applyStimulus(1, c == 0, 500, c);
    sendFrame(600, 0);
    checkOutput("drop_pulse_now", int'(err_drop), 0);
    waitDrain();
    checkOutput("drop_count", errDropCount - snapDrop, 1);
    checkOutput("drop_valid_cycles", validCount, 8);

    $display("[TB] reset during readout");
    sendFrame(700, 0);
    waitValid(found);
    checkOutput("mid_first_valid", int'(found), 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    monEnable = 0;
    @(posedge clk); #1;
    checkOutput("midrst_valid", int'(out_valid), 0);
    checkOutput("midrst_lanes", int'(out0_up | out0_down | out1_up | out1_down), 0);
    checkOutput("midrst_sof_eof", int'(out_sof) + int'(out_eof), 0);
    @(posedge clk); #1;
    rst = 1;
    sb.delete();
    monEnable = 1;
    snapValid = validCount;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("midrst_stays_idle", validCount - snapValid, 0);
    sendFrame(800, 0);
    waitDrain();
    checkOutput("post_rst_valid_cycles", validCount - snapValid, 8);

    $display("[TB] ten frames with random input gaps");
    snapDrop = errDropCount; validCount = 0;
    for (int f = 0; f < 10; f++) sendFrame(1000 + 100*f, 1);
    waitDrain();
    checkOutput("gaps_valid_cycles", validCount, 80);
    checkOutput("gaps_no_drop", errDropCount - snapDrop, 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
